// File: rtl/intp_service_arb.sv
// Interrupt service arbiter: edge-captures requests into a sticky pending vector and
// presents the highest-priority unmasked source until the processor acknowledges it.
module intp_service_arb #(
    parameter int NUM_OF_PERIPHERALS = 16,
    parameter int PRIO_WIDTH         = 4,
    parameter int ID_WIDTH           = $clog2(NUM_OF_PERIPHERALS)
) (
    input  logic                                     pclk_i,
    input  logic                                     prst_i,
    input  logic [NUM_OF_PERIPHERALS-1:0]            intp_active_i,
    input  logic [NUM_OF_PERIPHERALS*PRIO_WIDTH-1:0] priority_flat_i,
    input  logic                                     intp_serviced_i,
    output logic                                     intp_valid_o,
    output logic [ID_WIDTH-1:0]                      intp_to_service_o,
    output logic [NUM_OF_PERIPHERALS-1:0]            intp_clear_o,
    output logic [NUM_OF_PERIPHERALS-1:0]            pending_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_CLEAR    = 2'd2;

    localparam logic [NUM_OF_PERIPHERALS-1:0] ONE_LSB = {{(NUM_OF_PERIPHERALS-1){1'b0}}, 1'b1};

    logic [1:0]                    state_q, state_d;
    logic [NUM_OF_PERIPHERALS-1:0] active_q;
    logic [NUM_OF_PERIPHERALS-1:0] pending_q, pending_d;
    logic [NUM_OF_PERIPHERALS-1:0] clear_q, clear_d;
    logic [ID_WIDTH-1:0]           index_q, index_d;

    logic [NUM_OF_PERIPHERALS-1:0] rise;
    logic [NUM_OF_PERIPHERALS-1:0] clr_mask;
    logic [PRIO_WIDTH-1:0]         prio_arr [NUM_OF_PERIPHERALS];

    logic                          sel_found;
    logic [ID_WIDTH-1:0]           sel_idx;
    logic [PRIO_WIDTH-1:0]         sel_prio;

    always_comb begin
        for (int i = 0; i < NUM_OF_PERIPHERALS; i++) begin
            prio_arr[i] = priority_flat_i[i*PRIO_WIDTH +: PRIO_WIDTH];
        end
    end

    // Ascending scan with strict compare keeps the lowest index on priority ties.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_prio  = '0;
        for (int i = 0; i < NUM_OF_PERIPHERALS; i++) begin
            if (pending_q[i] && (prio_arr[i] > sel_prio)) begin
                sel_found = 1'b1;
                sel_idx   = ID_WIDTH'(i);
                sel_prio  = prio_arr[i];
            end
        end
    end

    assign rise = intp_active_i & ~active_q;

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        clear_d  = '0;
        clr_mask = '0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    index_d = sel_idx;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (intp_serviced_i) begin
                    clr_mask = ONE_LSB << index_q;
                    clear_d  = ONE_LSB << index_q;
                    state_d  = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A rise in the same cycle as the clear re-pends the source.
    assign pending_d = (pending_q & ~clr_mask) | rise;

    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state_q   <= ST_IDLE;
            active_q  <= '0;
            pending_q <= '0;
            clear_q   <= '0;
            index_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= intp_active_i;
            pending_q <= pending_d;
            clear_q   <= clear_d;
            index_q   <= index_d;
        end
    end

    assign intp_valid_o      = (state_q == ST_WAIT_ACK);
    assign intp_to_service_o = index_q;
    assign intp_clear_o      = clear_q;
    assign pending_o         = pending_q;

endmodule

// File: tb/tb_intp_service_arb.sv
// Directed bench for intp_service_arb: hand-computed expectations for capture,
// selection order, masking, re-arm, index stability and asynchronous reset.
module tb_intp_service_arb;

    logic        pclk_i;
    logic        prst_i;
    logic [15:0] intp_active_i;
    logic [63:0] priority_flat_i;
    logic        intp_serviced_i;
    logic        intp_valid_o;
    logic [3:0]  intp_to_service_o;
    logic [15:0] intp_clear_o;
    logic [15:0] pending_o;

    logic [3:0]  prio [16];
    int          checkCount;
    int          passCount;

    intp_service_arb #(
        .NUM_OF_PERIPHERALS(16),
        .PRIO_WIDTH(4),
        .ID_WIDTH(4)
    ) dut (
        .pclk_i(pclk_i),
        .prst_i(prst_i),
        .intp_active_i(intp_active_i),
        .priority_flat_i(priority_flat_i),
        .intp_serviced_i(intp_serviced_i),
        .intp_valid_o(intp_valid_o),
        .intp_to_service_o(intp_to_service_o),
        .intp_clear_o(intp_clear_o),
        .pending_o(pending_o)
    );

    initial pclk_i = 1'b0;
    always #5 pclk_i = ~pclk_i;

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            priority_flat_i[i*4 +: 4] = prio[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge pclk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] active, input logic serviced);
        intp_active_i   = active;
        intp_serviced_i = serviced;
    endtask

    task automatic clearPrios();
        for (int i = 0; i < 16; i++) prio[i] = 4'd0;
    endtask

    // Expects the DUT to be presenting expIdx; acks it and checks the clear pulse and gap.
    task automatic serviceOne(input string tag, input logic [3:0] expIdx);
        logic [15:0] oneHot;
        oneHot = 16'h0001 << expIdx;
        checkOutput({tag, "_valid"}, 32'(intp_valid_o), 32'd1);
        checkOutput({tag, "_idx"}, 32'(intp_to_service_o), 32'(expIdx));
        applyStimulus(intp_active_i, 1'b1);
        tick();
        checkOutput({tag, "_clear"}, 32'(intp_clear_o), 32'(oneHot));
        checkOutput({tag, "_gapValid"}, 32'(intp_valid_o), 32'd0);
        checkOutput({tag, "_pendCleared"}, 32'(pending_o[expIdx]), 32'd0);
        applyStimulus(intp_active_i, 1'b0);
        tick();
        checkOutput({tag, "_clearDone"}, 32'(intp_clear_o), 32'd0);
        checkOutput({tag, "_idleValid"}, 32'(intp_valid_o), 32'd0);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        clearPrios();
        prst_i = 1'b0;
        applyStimulus(16'h0000, 1'b0);
        repeat (3) tick();
        prst_i = 1'b1;
        tick();
        checkOutput("rst_valid", 32'(intp_valid_o), 32'd0);
        checkOutput("rst_idx", 32'(intp_to_service_o), 32'd0);
        checkOutput("rst_clear", 32'(intp_clear_o), 32'd0);
        checkOutput("rst_pending", 32'(pending_o), 32'd0);

        // Single source 5 with latency check
        prio[5] = 4'd3;
        applyStimulus(16'h0020, 1'b0);
        tick();
        checkOutput("single_pend", 32'(pending_o), 32'h0020);
        checkOutput("single_validEarly", 32'(intp_valid_o), 32'd0);
        tick();
        serviceOne("single", 4'd5);
        tick();
        checkOutput("single_noRepend", 32'(pending_o), 32'h0000);
        checkOutput("single_noRevalid", 32'(intp_valid_o), 32'd0);
        applyStimulus(16'h0000, 1'b1);
        tick();
        checkOutput("ackIgnored_clear", 32'(intp_clear_o), 32'd0);
        applyStimulus(16'h0000, 1'b0);
        tick();

        // Priority: 9 (12) before 2 (7)
        clearPrios();
        prio[2] = 4'd7;
        prio[9] = 4'd12;
        applyStimulus(16'h0204, 1'b0);
        tick();
        checkOutput("prio_pend", 32'(pending_o), 32'h0204);
        tick();
        serviceOne("prio_first", 4'd9);
        tick();
        serviceOne("prio_second", 4'd2);
        applyStimulus(16'h0000, 1'b0);
        tick();

        // Tie goes to lowest index, masked source 0 waits
        clearPrios();
        prio[1] = 4'd5;
        prio[4] = 4'd5;
        applyStimulus(16'h0013, 1'b0);
        tick();
        checkOutput("tie_pend", 32'(pending_o), 32'h0013);
        tick();
        serviceOne("tie_first", 4'd1);
        tick();
        serviceOne("tie_second", 4'd4);
        tick();
        checkOutput("mask_valid", 32'(intp_valid_o), 32'd0);
        checkOutput("mask_pend", 32'(pending_o), 32'h0001);
        prio[0] = 4'd1;
        tick();
        serviceOne("unmask", 4'd0);
        applyStimulus(16'h0000, 1'b0);
        tick();

        // Re-arm: source 3 drops during ack and rises again on the clear edge
        clearPrios();
        prio[3] = 4'd2;
        applyStimulus(16'h0008, 1'b0);
        tick();
        tick();
        checkOutput("rearm_idx", 32'(intp_to_service_o), 32'd3);
        applyStimulus(16'h0000, 1'b1);
        tick();
        checkOutput("rearm_clear", 32'(intp_clear_o), 32'h0008);
        applyStimulus(16'h0008, 1'b0);
        tick();
        checkOutput("rearm_pend", 32'(pending_o), 32'h0008);
        tick();
        serviceOne("rearm_again", 4'd3);
        applyStimulus(16'h0000, 1'b0);
        tick();

        // Stability: higher-priority arrival does not disturb the presented index
        clearPrios();
        prio[6] = 4'd4;
        applyStimulus(16'h0040, 1'b0);
        tick();
        tick();
        checkOutput("stable_idx0", 32'(intp_to_service_o), 32'd6);
        prio[10] = 4'd15;
        applyStimulus(16'h0440, 1'b0);
        tick();
        checkOutput("stable_pend", 32'(pending_o), 32'h0440);
        checkOutput("stable_idx1", 32'(intp_to_service_o), 32'd6);
        tick();
        serviceOne("stable_first", 4'd6);
        tick();
        serviceOne("stable_next", 4'd10);
        applyStimulus(16'h0000, 1'b0);
        tick();

        // Asynchronous reset while presenting
        clearPrios();
        prio[7] = 4'd1;
        applyStimulus(16'h0080, 1'b0);
        tick();
        tick();
        checkOutput("arst_preValid", 32'(intp_valid_o), 32'd1);
        #2;
        prst_i = 1'b0;
        #1;
        checkOutput("arst_valid", 32'(intp_valid_o), 32'd0);
        checkOutput("arst_idx", 32'(intp_to_service_o), 32'd0);
        checkOutput("arst_clear", 32'(intp_clear_o), 32'd0);
        checkOutput("arst_pending", 32'(pending_o), 32'd0);
        applyStimulus(16'h0000, 1'b0);
        tick();
        prst_i = 1'b1;
        tick();
        checkOutput("arst_after", 32'(pending_o), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
